// File: rtl/fir_pkg.sv
// Shared constants for the 4-tap CSKA FIR slice.
//   W_DEF       : default operand width (two's complement)
//   BLK_DEF     : default carry-skip block size
//   num_blocks(): number of carry-skip blocks, ceil(n/blk)
package fir_pkg;

    localparam int unsigned W_DEF   = 16;
    localparam int unsigned BLK_DEF = 4;

    function automatic int unsigned num_blocks(input int unsigned n, input int unsigned blk);
        return (n + blk - 1) / blk;
    endfunction

endpackage

// File: rtl/csk_adder.sv
// N-bit carry-skip adder built from BLK-bit ripple blocks.
// Ports:
//   x, y : N-bit addends
//   cin  : carry into bit 0
//   sum  : N-bit sum (modulo 2^N)
//   cout : carry out of bit N-1
module csk_adder
    import fir_pkg::*;
#(
    parameter int unsigned N   = 17,
    parameter int unsigned BLK = BLK_DEF
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned NB = num_blocks(N, BLK);

    for (genvar b = 0; b < NB; b++) begin : g_blk
        localparam int unsigned LO = b * BLK;
        // Last block is truncated when N is not a multiple of BLK.
        localparam int unsigned HI = (LO + BLK > N) ? (N - 1) : (LO + BLK - 1);
        localparam int unsigned WB = HI - LO + 1;

        logic          ci;
        logic          co;
        logic          bp;
        logic          rco;
        logic [WB-1:0] bs;

        if (b == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_blk[b-1].co;
        end

        // Ripple sum inside the block.
        assign {rco, bs} = (WB+1)'(x[HI:LO]) + (WB+1)'(y[HI:LO]) + (WB+1)'(ci);

        // When every bit propagates, the block carry-out is just its carry-in.
        assign bp  = &(x[HI:LO] ^ y[HI:LO]);
        assign co  = bp ? ci : rco;

        assign sum[HI:LO] = bs;
    end

    assign cout = g_blk[NB-1].co;

endmodule

// File: rtl/fir4_carry_skip_adder_u.sv
// 4-tap unweighted-sum FIR: s <= ar + br + cr + dr, all adds on carry-skip adders.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, clears taps and output
//   a     : w-bit signed input sample, captured every edge
//   s     : (w+2)-bit signed registered sum of the four taps
module fir4_carry_skip_adder_u
    import fir_pkg::*;
#(
    parameter int unsigned w   = W_DEF,
    parameter int unsigned BLK = BLK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [w-1:0] a,
    output logic signed [w+1:0] s
);

    logic [w-1:0] ar, br, cr, dr;
    logic [w:0]   p0, p1;
    logic [w+1:0] s_next;
    logic         p0_co, p1_co, s_co;
    logic         unused_cout;

    // Pair sums on sign-extended taps, then the final sum; widths cannot overflow,
    // so the carry-outs carry no information.
    csk_adder #(.N(w + 1), .BLK(BLK)) u_p0 (
        .x    ({ar[w-1], ar}),
        .y    ({br[w-1], br}),
        .cin  (1'b0),
        .sum  (p0),
        .cout (p0_co)
    );

    csk_adder #(.N(w + 1), .BLK(BLK)) u_p1 (
        .x    ({cr[w-1], cr}),
        .y    ({dr[w-1], dr}),
        .cin  (1'b0),
        .sum  (p1),
        .cout (p1_co)
    );

    csk_adder #(.N(w + 2), .BLK(BLK)) u_s (
        .x    ({p0[w], p0}),
        .y    ({p1[w], p1}),
        .cin  (1'b0),
        .sum  (s_next),
        .cout (s_co)
    );

    assign unused_cout = p0_co ^ p1_co ^ s_co;

    // Tap delay line and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar <= '0;
            br <= '0;
            cr <= '0;
            dr <= '0;
            s  <= '0;
        end else begin
            ar <= a;
            br <= ar;
            cr <= br;
            dr <= cr;
            s  <= s_next;
        end
    end

endmodule

// File: tb/tb_fir4_carry_skip_adder_u.sv
module tb_fir4_carry_skip_adder_u;

    logic               clk;
    logic               reset;
    logic signed [15:0] a16;
    logic signed [17:0] s16;
    logic signed [7:0]  a8;
    logic signed [9:0]  s8;
    logic signed [31:0] a32;
    logic signed [33:0] s32;

    int nchk = 0;
    int nbad = 0;

    longint t16[4];
    longint t8[4];
    longint t32[4];
    longint e16, e8, e32;

    fir4_carry_skip_adder_u #(.w(16), .BLK(4)) dut16 (.clk(clk), .reset(reset), .a(a16), .s(s16));
    fir4_carry_skip_adder_u #(.w(8),  .BLK(3)) dut8  (.clk(clk), .reset(reset), .a(a8),  .s(s8));
    fir4_carry_skip_adder_u #(.w(32), .BLK(5)) dut32 (.clk(clk), .reset(reset), .a(a32), .s(s32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            t16[i] = 0;
            t8[i]  = 0;
            t32[i] = 0;
        end
        e16 = 0;
        e8  = 0;
        e32 = 0;
    endtask

    // Advance one edge, then update the reference delay lines with the sampled inputs.
    task automatic tick();
        @(posedge clk);
        #1;
        e16 = t16[0] + t16[1] + t16[2] + t16[3];
        e8  = t8[0]  + t8[1]  + t8[2]  + t8[3];
        e32 = t32[0] + t32[1] + t32[2] + t32[3];
        for (int i = 3; i > 0; i--) begin
            t16[i] = t16[i-1];
            t8[i]  = t8[i-1];
            t32[i] = t32[i-1];
        end
        t16[0] = longint'(a16);
        t8[0]  = longint'(a8);
        t32[0] = longint'(a32);
    endtask

    // Pulse reset between edges and check the asynchronous clear.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_s16"}, 64'(s16), 64'sd0);
        chk({tag, "_s8"},  64'(s8),  64'sd0);
        chk({tag, "_s32"}, 64'(s32), 64'sd0);
        model_clear();
        a16 = '0;
        a8  = '0;
        a32 = '0;
        #2;
        reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "16"}, 64'(s16), 64'(e16));
        chk({tag, "8"},  64'(s8),  64'(e8));
        chk({tag, "32"}, 64'(s32), 64'(e32));
    endtask

    longint exp_maxp[6] = '{0, 32767, 65534, 98301, 131068, 131068};
    longint exp_minn[6] = '{0, -32768, -65536, -98304, -131072, -131072};
    longint exp_imp[7]  = '{0, 1, 1, 1, 1, 0, 0};

    initial begin
        reset = 1'b1;
        a16   = 'x;
        a8    = 'x;
        a32   = 'x;
        model_clear();
        #3;
        chk("rst_s16", 64'(s16), 64'sd0);
        chk("rst_s8",  64'(s8),  64'sd0);
        chk("rst_s32", 64'(s32), 64'sd0);
        #5;
        reset = 1'b0;
        a16 = '0;
        a8  = '0;
        a32 = '0;

        // Impulse: one sample of 1 contributes for exactly four cycles.
        a16 = 16'sd1;
        for (int i = 0; i < 7; i++) begin
            tick();
            a16 = '0;
            chk($sformatf("imp%0d", i), 64'(s16), 64'(exp_imp[i]));
        end

        // Max positive ramp.
        do_reset("r1");
        a16 = 16'sh7FFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("maxp%0d", i), 64'(s16), 64'(exp_maxp[i]));
        end

        // Min negative ramp, full sign extension.
        do_reset("r2");
        a16 = 16'sh8000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("minn%0d", i), 64'(s16), 64'(exp_minn[i]));
        end

        // Alternating -1/+1 drives long propagate chains; sum settles to 0.
        do_reset("r3");
        for (int i = 0; i < 10; i++) begin
            a16 = (i % 2 == 0) ? 16'shFFFF : 16'sh0001;
            tick();
            chk($sformatf("alt%0d", i), 64'(s16), (i == 1 || i == 3) ? -64'sd1 : 64'sd0);
        end

        // Random stream, reset mid-stream, then refill from zeros.
        do_reset("r4");
        for (int i = 0; i < 6; i++) begin
            a16 = 16'($urandom);
            a8  = 8'($urandom);
            a32 = 32'($urandom);
            tick();
            check_model("pre");
        end
        do_reset("mid");
        for (int i = 0; i < 6; i++) begin
            a16 = 16'($urandom);
            a8  = 8'($urandom);
            a32 = 32'($urandom);
            tick();
            check_model("post");
        end

        // Long random run across all three widths.
        for (int i = 0; i < 30; i++) begin
            a16 = 16'($urandom);
            a8  = 8'($urandom);
            a32 = 32'($urandom);
            tick();
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
